// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch: PC sequencing, one outstanding imem request, instruction buffer
// Optional macro IFU_MISALIGN_CHK_EN: flag and halt fetch on misaligned redirect targets.
module ifu_fetch #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  output logic            misalign
);

  localparam int unsigned      PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_addr_q, req_addr_d;
  logic             drop_q, drop_d;
  logic             misalign_q, misalign_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, count_nxt;
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];
  logic [XLEN-1:0]  buf_pc_q [BUF_DEPTH];
  logic [XLEN-1:0]  buf_pc_d [BUF_DEPTH];

  logic             outstanding, credit, accept, push, pop;
  logic             redir_misaligned;
  logic [XLEN-1:0]  redir_target;
  logic [CNT_W:0]   used;

`ifdef IFU_MISALIGN_CHK_EN
  assign redir_target     = redirect_pc;
  assign redir_misaligned = |redirect_pc[1:0];
  assign misalign         = misalign_q;
`else
  assign redir_target     = redirect_pc & ~XLEN'(3);
  assign redir_misaligned = 1'b0;
  assign misalign         = 1'b0;
`endif

  // A dropped response still occupies the single request slot until it returns.
  assign outstanding    = (state_q == S_WAIT) || drop_q;
  assign used           = {1'b0, count_q} + {{CNT_W{1'b0}}, outstanding};
  assign credit         = used < {1'b0, DEPTH_C};
  assign imem_req_valid = (state_q == S_REQ) && credit && !drop_q && !misalign_q;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign push      = imem_rsp_valid && (state_q == S_WAIT) && !drop_q && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? buf_inst_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q] : '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: if (credit) state_d = S_REQ;
      S_REQ: begin
        if (accept) begin
          state_d    = S_WAIT;
          pc_d       = pc_q + XLEN'(4);
          req_addr_d = pc_q;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) state_d = (count_nxt < DEPTH_C) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (drop_q && imem_rsp_valid) drop_d = 1'b0;
    // Redirect overrides everything decided above in the same cycle.
    if (redirect_valid) begin
      state_d    = S_REQ;
      pc_d       = redir_target;
      drop_d     = (outstanding && !imem_rsp_valid) || accept;
      misalign_d = redir_misaligned;
    end
  end

  always_comb begin
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_nxt;
    if (push) begin
      buf_inst_d[wr_ptr_q] = imem_rsp_data;
      buf_pc_d[wr_ptr_q]   = req_addr_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      buf_inst_q <= '{default: '0};
      buf_pc_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with a behavioural memory and stream model
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] req_log[$];

  bit          mem_ready_rand = 1'b0;
  bit          mem_ready_en = 1'b1;
  int          mem_lat_min = 1;
  int          mem_lat_max = 1;
  bit          mem_busy = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_addr = '0;
  int          overlap_err = 0;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers each accepted request after mem_lat cycles; reset together with the DUT.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (!rst) begin
        mem_busy       = 1'b0;
        imem_req_ready = 1'b0;
      end else begin
        if (mem_busy) begin
          if (mem_delay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_busy       = 1'b0;
          end else mem_delay = mem_delay - 1;
        end
        imem_req_ready = mem_ready_rand ? ($urandom_range(0, 1) == 1) : mem_ready_en;
        if (imem_req_valid && imem_req_ready) begin
          if (mem_busy) overlap_err++;
          mem_busy  = 1'b1;
          mem_addr  = imem_req_addr;
          mem_delay = $urandom_range(mem_lat_min, mem_lat_max) - 1;
          req_log.push_back(imem_req_addr);
        end
      end
    end
  end

  // Records every instruction decode actually consumes.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid && out_ready && !redirect_valid) begin
        got_pc.push_back(out_pc);
        got_inst.push_back(out_inst);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    mem_ready_rand = 1'b0; mem_ready_en = 1'b1; mem_lat_min = 1; mem_lat_max = 1;
    repeat (3) tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (imem_req_addr !== RESET_PC) begin failures++; $display("FAIL reset_pc: got %h want %h", imem_req_addr, RESET_PC); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_inst, out_pc); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    req_log.delete(); got_pc.delete(); got_inst.delete();
    rst = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin failures++; $display("FAIL first_req: got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_out_valid: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin failures++; $display("FAIL first_out: got %b/%h want 1/%h", out_valid, out_pc, RESET_PC); end
    checks++; if (out_inst !== mem_word(RESET_PC)) begin failures++; $display("FAIL first_inst: got %h want %h", out_inst, mem_word(RESET_PC)); end
    exp_pc = RESET_PC;
  endtask

  task automatic test_sequential();
    logic [31:0] p, w;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got_pc.size() < 3; c++) tick();
    checks++; if (got_pc.size() < 3) begin failures++; $display("FAIL seq_timeout: got %0d insts want 3", got_pc.size()); end
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      checks++; if (req_log[i] !== RESET_PC + 32'(4 * i)) begin failures++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, req_log[i], RESET_PC + 32'(4 * i)); end
    end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc) begin failures++; $display("FAIL seq_pc: got %h want %h", p, exp_pc); end
      checks++; if (w !== mem_word(exp_pc)) begin failures++; $display("FAIL seq_inst: got %h want %h", w, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p, w;
    out_ready = 1'b0;
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL bp_pre: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) begin
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL bp_hold_pc: got %h want %h", out_pc, exp_pc); end
      end
    end
    checks++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_full: got valid=%b req=%b want 1/0", out_valid, imem_req_valid); end
    checks++; if (out_inst !== mem_word(exp_pc)) begin failures++; $display("FAIL bp_hold_inst: got %h want %h", out_inst, mem_word(exp_pc)); end
    mem_ready_en = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    checks++; if (got_pc.size() != BUF_DEPTH) begin failures++; $display("FAIL bp_count: got %0d want %0d", got_pc.size(), BUF_DEPTH); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL bp_drain_order: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
    mem_ready_en = 1'b1;
  endtask

  task automatic test_redirect_wait();
    logic [31:0] p, w;
    bit found = 1'b0;
    out_ready = 1'b1; mem_lat_min = 3; mem_lat_max = 3;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (mem_busy && !imem_req_valid) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rw_wait_timeout: got no WAIT want WAIT"); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL rw_pre: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    exp_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rw_flush: got %b want 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rw_drop_block: got %b want 0", imem_req_valid); end
    for (int c = 0; c < 60 && got_pc.size() < 2; c++) tick();
    checks++; if (got_pc.size() < 2) begin failures++; $display("FAIL rw_timeout: got %0d insts want 2", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL rw_post: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_redirect_coincident();
    logic [31:0] p, w;
    bit found = 1'b0;
    out_ready = 1'b1; mem_lat_min = 1; mem_lat_max = 1;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (imem_rsp_valid) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rc_timeout: got no response want one"); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL rc_pre: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    exp_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rc_empty: got %b want 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin failures++; $display("FAIL rc_next_req: got %b/%h want 1/80000300", imem_req_valid, imem_req_addr); end
    for (int c = 0; c < 40 && got_pc.size() < 2; c++) tick();
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL rc_post: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] p, w;
    out_ready = 1'b1;
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL wrap_pre: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    exp_pc = 32'hFFFF_FFFC;
    req_log.delete();
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 60 && (req_log.size() < 2 || got_pc.size() < 2); c++) tick();
    checks++; if (req_log.size() < 2) begin failures++; $display("FAIL wrap_timeout: got %0d reqs want 2", req_log.size()); end
    else begin
      checks++; if (req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", req_log[0], req_log[1]); end
    end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL wrap_out: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_misalign();
    logic [31:0] p, w;
    out_ready = 1'b1;
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL mis_pre: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    req_log.delete();
    tick();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    checks++; if (misalign !== 1'b1 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_set: got %b/%b want 1/0", misalign, imem_req_valid); end
    repeat (10) tick();
    checks++; if (req_log.size() != 0 || got_pc.size() != 0) begin failures++; $display("FAIL mis_halt: got %0d reqs %0d insts want 0/0", req_log.size(), got_pc.size()); end
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_sticky: got %b want 1", misalign); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_clear: got %b want 0", misalign); end
    exp_pc = 32'h8000_0200;
`else
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_tied: got %b want 0", misalign); end
    exp_pc = 32'h8000_0100;
`endif
    for (int c = 0; c < 60 && (req_log.size() < 1 || got_pc.size() < 2); c++) tick();
    checks++; if (req_log.size() < 1) begin failures++; $display("FAIL mis_resume_timeout: got 0 reqs want 1"); end
    else begin
      checks++; if (req_log[0] !== exp_pc) begin failures++; $display("FAIL mis_resume_addr: got %h want %h", req_log[0], exp_pc); end
    end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL mis_out: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_reset_midwait();
    logic [31:0] p, w;
    bit found = 1'b0;
    out_ready = 1'b1; mem_lat_min = 3; mem_lat_max = 3;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (mem_busy && !imem_req_valid) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rm_wait_timeout: got no WAIT want WAIT"); end
    rst = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL rm_in_reset: got %b/%b want 0/0", out_valid, imem_req_valid); end
    got_pc.delete(); got_inst.delete(); req_log.delete();
    exp_pc = RESET_PC;
    rst = 1'b1;
    for (int c = 0; c < 60 && got_pc.size() < 2; c++) tick();
    checks++; if (req_log.size() < 1 || req_log[0] !== RESET_PC) begin failures++; $display("FAIL rm_first_req: got %0d reqs want first %h", req_log.size(), RESET_PC); end
    checks++; if (got_pc.size() < 2) begin failures++; $display("FAIL rm_timeout: got %0d insts want 2", got_pc.size()); end
    while (got_pc.size() > 0) begin
      p = got_pc.pop_front(); w = got_inst.pop_front();
      checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL rm_out: got %h/%h want %h/%h", p, w, exp_pc, mem_word(exp_pc)); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_random();
    logic [31:0] p, w;
    bit prev_redir = 1'b0;
    int pops = 0;
    mem_ready_rand = 1'b1; mem_lat_min = 1; mem_lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (prev_redir) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_flush: cycle %0d got %b want 0", c, out_valid); end
      end
      while (got_pc.size() > 0) begin
        p = got_pc.pop_front(); w = got_inst.pop_front();
        pops++;
        checks++; if (p !== exp_pc || w !== mem_word(exp_pc)) begin failures++; $display("FAIL rnd_stream: cycle %0d got %h/%h want %h/%h", c, p, w, exp_pc, mem_word(exp_pc)); end
        exp_pc += 32'd4;
      end
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      out_ready      = ($urandom_range(0, 3) != 0);
      if (redirect_valid) exp_pc = redirect_pc;
      prev_redir = redirect_valid;
    end
    redirect_valid = 1'b0;
    mem_ready_rand = 1'b0;
    checks++; if (overlap_err != 0) begin failures++; $display("FAIL rnd_outstanding: got %0d overlaps want 0", overlap_err); end
    checks++; if (pops < 200) begin failures++; $display("FAIL rnd_progress: got %0d insts want >=200", pops); end
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_misalign();
    test_reset_midwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
